// File: rtl/axis_xc_tx_lane_pkg.sv
// Shared types and constants for the XC transmit lane (package xc_tx_pkg).
// Used by axis_xc_tx_lane; see that file for the XC_TX_TIMEOUT_EN option.
package xc_tx_pkg;

  localparam int XC_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } xc_tx_state_e;

  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } xc_half_e;

  // Last wait-counter value before the timeout fires; the counter starts at 0
  // on the first wait cycle, so N cycles of waiting end at count N-1.
  function automatic logic [15:0] wait_last(input int cycles);
    return (cycles < 1) ? 16'd0 : 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/axis_xc_tx_lane_ack_sync.sv
// xc_ack_sync: flop chain bringing the chip acknowledge into the clock domain.
// Clears to 0 on asynchronous active-low reset. SYNC_STAGES must be >= 2.
module xc_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw acknowledge through the chain; only the last flop is used.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/axis_xc_tx_lane.sv
// axis_xc_tx_lane: accepts 64-bit AXI-Stream frames and sends each one to the
// chip as two 32-bit words (high half first) over a 4-phase req/ack handshake.
// Optional macro XC_TX_TIMEOUT_EN adds an acknowledge wait limit with a sticky
// ack_timeout flag; without it the lane waits forever for the chip.
//
// state   | meaning
// IDLE    | ready for a frame (tready registered high one cycle after entry)
// SETUP   | dout presents the selected half, request still low
// REQ     | request high, waiting for synchronized ack high
// RELEASE | request low, waiting for synchronized ack low
module axis_xc_tx_lane
  import xc_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 2 * XC_WIDTH_DEFAULT,
  parameter int XC_WIDTH       = XC_WIDTH_DEFAULT,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  acknowledge,
  output logic [XC_WIDTH-1:0]   dout,
  output logic                  request,
  output logic                  busy,
  output logic                  o_tx_done,
  input  logic                  err_clr,
  output logic                  ack_timeout
);

  // A single-flop synchronizer is never acceptable for the async chip ack.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  xc_tx_state_e        r_state;
  xc_half_e            r_half;
  logic [XC_WIDTH-1:0] r_data_lo;
  logic                r_last;
  logic [XC_WIDTH-1:0] r_dout;
  logic                r_request;
  logic                r_tready;
  logic                r_done;
  logic                w_ack_s;
  logic                w_expired;

  xc_ack_sync #(
    .SYNC_STAGES(STAGES)
  ) u_ack_sync (
    .i_clk  (s_axis_aclk),
    .i_rst_n(s_axis_aresetn),
    .i_async(acknowledge),
    .o_sync (w_ack_s)
  );

`ifdef XC_TX_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = wait_last(TIMEOUT_CYCLES);

  logic [15:0] r_wait;
  logic        r_ack_timeout;
  logic        w_waiting;

  // Waiting means staying in REQ or RELEASE for another cycle; any other
  // cycle (including the one that enters REQ/RELEASE) leaves the count at 0.
  assign w_waiting = ((r_state == ST_REQ) && !w_ack_s) ||
                     ((r_state == ST_RELEASE) && w_ack_s);
  assign w_expired = w_waiting && (r_wait == WAIT_LAST);

  // Wait counter and sticky timeout flag; a new timeout beats err_clr.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_wait        <= '0;
      r_ack_timeout <= 1'b0;
    end else begin
      if (w_waiting) begin
        r_wait <= r_wait + 16'd1;
      end else begin
        r_wait <= '0;
      end
      if (w_expired) begin
        r_ack_timeout <= 1'b1;
      end else if (err_clr) begin
        r_ack_timeout <= 1'b0;
      end
    end
  end

  assign ack_timeout = r_ack_timeout;
`else
  logic w_unused_cfg;

  assign w_expired    = 1'b0;
  assign ack_timeout  = 1'b0;
  assign w_unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

  // Lane FSM with registered tready, dout, request and done pulse.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state   <= ST_IDLE;
      r_half    <= HALF_HI;
      r_data_lo <= '0;
      r_last    <= 1'b0;
      r_dout    <= '0;
      r_request <= 1'b0;
      r_tready  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_tready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_tready && s_axis_tvalid) begin
            // Only the low half needs keeping; the high half goes straight out.
            r_data_lo <= s_axis_tdata[XC_WIDTH-1:0];
            r_last    <= s_axis_tlast;
            r_half    <= HALF_HI;
            r_dout    <= s_axis_tdata[DATA_WIDTH-1:XC_WIDTH];
            r_state   <= ST_SETUP;
          end else begin
            r_tready <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_request <= 1'b1;
          r_state   <= ST_REQ;
        end
        ST_REQ: begin
          // An ack arriving on the limit cycle still counts as success.
          if (w_ack_s) begin
            r_request <= 1'b0;
            r_state   <= ST_RELEASE;
          end else if (w_expired) begin
            r_request <= 1'b0;
            r_half    <= HALF_HI;
            r_state   <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (!w_ack_s) begin
            if (r_half == HALF_HI) begin
              r_half  <= HALF_LO;
              r_dout  <= r_data_lo;
              r_state <= ST_SETUP;
            end else begin
              r_done  <= r_last;
              r_state <= ST_IDLE;
            end
          end else if (w_expired) begin
            r_half  <= HALF_HI;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_request <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign dout          = r_dout;
  assign request       = r_request;
  assign o_tx_done     = r_done;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axis_xc_tx_lane.sv
// Testbench for axis_xc_tx_lane: table vectors, back-to-back packets, frame
// period, random frames against a word-queue model, reset mid-handshake and
// acknowledge-timeout behaviour (either build of XC_TX_TIMEOUT_EN).
module tb_axis_xc_tx_lane;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tready;
  logic [63:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        acknowledge;
  logic [31:0] dout;
  logic        request;
  logic        busy;
  logic        tx_done;
  logic        err_clr = 1'b0;
  logic        ack_timeout;

  always #5 clk = ~clk;

  axis_xc_tx_lane #(
    .DATA_WIDTH(64),
    .XC_WIDTH(32),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tready (tready),
    .s_axis_tdata  (tdata),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
    .acknowledge   (acknowledge),
    .dout          (dout),
    .request       (request),
    .busy          (busy),
    .o_tx_done     (tx_done),
    .err_clr       (err_clr),
    .ack_timeout   (ack_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- cycle counter ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- chip model ----------------
  // Follows request after chip_delay cycles; acts just after the falling edge.
  logic chip_en = 1'b1;
  int   chip_delay = 3;
  initial begin
    int cnt;
    cnt = 0;
    acknowledge = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (chip_en && (request !== acknowledge)) begin
        if (cnt >= chip_delay) begin
          acknowledge = request;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  // Each accepted frame becomes two expected words; the low word carries tlast
  // as the "done expected after this word" flag.
  logic [31:0] exp_words[$];
  logic        exp_flags[$];
  logic [31:0] cap_q[$];
  logic        pending_done = 1'b0;
  int          n_words = 0;
  int          n_done = 0;
  int          done_at_word = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_dout = '0;
  logic [31:0] mon_w;
  logic        mon_f;
  int          acc_cycle = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (request && !prev_req) begin
        check("req_rise_ack_low", acknowledge, 0);
        check("dout_setup_stable", dout, prev_dout);
        if (exp_words.size() == 0) begin
          check("unexpected_word", dout, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_w = exp_words.pop_front();
          mon_f = exp_flags.pop_front();
          check("word", dout, mon_w);
          pending_done = mon_f;
        end
        cap_q.push_back(dout);
        n_words++;
      end
      if (request && prev_req) check("dout_hold", dout, prev_dout);
      if (!request && prev_req && chip_en) check("req_fall_ack_high", acknowledge, 1);
      if (tx_done) begin
        n_done++;
        done_at_word = n_words;
        check("done_position", pending_done, 1);
        pending_done = 1'b0;
      end
      if (busy) check("tready_low_busy", tready, 0);
    end
    prev_req  = request;
    prev_dout = dout;
  end

  // ---------------- driver helpers ----------------
  task automatic send_frame(input logic [63:0] d, input logic l);
    int w;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    w = 0;
    while (tready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (tready !== 1'b1) begin
      check("accept_timeout", tready, 1);
    end else begin
      exp_words.push_back(d[63:32]);
      exp_flags.push_back(1'b0);
      exp_words.push_back(d[31:0]);
      exp_flags.push_back(l);
      acc_cycle = cyc;
    end
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while ((exp_words.size() != 0 || busy || request) && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (w >= budget) check("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_request(input int budget);
    int w;
    w = 0;
    while (request !== 1'b1 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (request !== 1'b1) check("request_rise_timeout", request, 1);
  endtask

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, w0, a0, nl, to_cyc, r0;
    logic bad_req, bad_to;
    logic [31:0] abc_exp[6];
    logic [63:0] rd;
    logic rl;

    vecs[0] = '{64'h1122_3344_5566_7788, 1'b1, 32'h1122_3344, 32'h5566_7788, 1};
    vecs[1] = '{64'hFFFF_FFFF_0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vecs[2] = '{64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1};
    vecs[3] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0};
    vecs[4] = '{64'h0000_0001_8000_0000, 1'b1, 32'h0000_0001, 32'h8000_0000, 1};
    abc_exp = '{32'hA0A1_A2A3, 32'hA4A5_A6A7, 32'hB0B1_B2B3,
                32'hB4B5_B6B7, 32'hC0C1_C2C3, 32'hC4C5_C6C7};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_dout", dout, 0);
    check("rst_request", request, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ack_timeout", ack_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_reset", tready, 1);

    // ---- table vectors, chip acks ~3 cycles after each edge ----
    chip_delay = 3;
    for (int i = 0; i < 5; i++) begin
      cap_q.delete();
      d0 = n_done;
      send_frame(vecs[i].data, vecs[i].last);
      wait_idle(400);
      check("vec_word_count", cap_q.size(), 2);
      if (cap_q.size() >= 2) begin
        check("vec_hi", cap_q[0], vecs[i].exp_hi);
        check("vec_lo", cap_q[1], vecs[i].exp_lo);
      end
      check("vec_done_count", n_done - d0, vecs[i].exp_done);
    end

    // ---- A, B (no tlast) then C (tlast) back-to-back ----
    chip_delay = 1;
    cap_q.delete();
    d0 = n_done;
    w0 = n_words;
    send_frame(64'hA0A1_A2A3_A4A5_A6A7, 1'b0);
    send_frame(64'hB0B1_B2B3_B4B5_B6B7, 1'b0);
    send_frame(64'hC0C1_C2C3_C4C5_C6C7, 1'b1);
    wait_idle(600);
    check("abc_word_count", cap_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < cap_q.size()) check("abc_word", cap_q[i], abc_exp[i]);
    end
    check("abc_done_count", n_done - d0, 1);
    check("abc_done_after_word6", done_at_word - w0, 6);

    // ---- frame period with instantaneous chip, SYNC_STAGES=2 ----
    chip_delay = 0;
    send_frame(64'h0123_4567_89AB_CDEF, 1'b0);
    a0 = acc_cycle;
    send_frame(64'hFEDC_BA98_7654_3210, 1'b1);
    check("frame_period", acc_cycle - a0, 16);
    wait_idle(200);

    // ---- random frames against the model ----
    d0 = n_done;
    w0 = n_words;
    nl = 0;
    for (int i = 0; i < 24; i++) begin
      rd = {$urandom(), $urandom()};
      rl = 1'($urandom_range(0, 1));
      chip_delay = $urandom_range(0, 4);
      if (rl) nl++;
      send_frame(rd, rl);
      if ($urandom_range(0, 3) == 0) wait_idle(400);
    end
    wait_idle(2000);
    check("rand_words", n_words - w0, 48);
    check("rand_dones", n_done - d0, nl);
    check("rand_queue_empty", exp_words.size(), 0);

    // ---- reset while in REQ of the high half ----
    chip_en = 1'b0;
    send_frame(64'h5A5A_5A5A_A5A5_A5A5, 1'b1);
    wait_request(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_request", request, 0);
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    exp_words.delete();
    exp_flags.delete();
    pending_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_tready", tready, 1);
    chip_en = 1'b1;
    chip_delay = 2;
    cap_q.delete();
    d0 = n_done;
    send_frame(64'h600D_F00D_1234_ABCD, 1'b1);
    wait_idle(400);
    check("post_rst_words", cap_q.size(), 2);
    if (cap_q.size() >= 2) begin
      check("post_rst_hi", cap_q[0], 32'h600D_F00D);
      check("post_rst_lo", cap_q[1], 32'h1234_ABCD);
    end
    check("post_rst_done", n_done - d0, 1);

    // ---- acknowledge never arrives ----
    chip_en = 1'b0;
    cap_q.delete();
    d0 = n_done;
    send_frame(64'h7777_8888_9999_AAAA, 1'b1);
    wait_request(20);
    r0 = cyc;
`ifdef XC_TX_TIMEOUT_EN
    to_cyc = 0;
    for (int i = 0; i < 300 && ack_timeout !== 1'b1; i++) @(negedge clk);
    to_cyc = cyc;
    check("timeout_flag", ack_timeout, 1);
    check("timeout_latency", to_cyc - r0, 100);
    check("timeout_request_low", request, 0);
    check("timeout_idle", busy, 0);
    repeat (5) @(negedge clk);
    check("timeout_sticky", ack_timeout, 1);
    check("timeout_tready", tready, 1);
    check("timeout_no_done", n_done - d0, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_cleared", ack_timeout, 0);
    exp_words.delete();
    exp_flags.delete();
    pending_done = 1'b0;
`else
    bad_req = 1'b0;
    bad_to  = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (request !== 1'b1) bad_req = 1'b1;
      if (ack_timeout !== 1'b0) bad_to = 1'b1;
    end
    check("notimeout_request_held", bad_req, 0);
    check("notimeout_flag_zero", bad_to, 0);
    check("notimeout_waited", cyc - r0 >= 10000, 1);
    chip_en = 1'b1;
    chip_delay = 1;
    wait_idle(200);
    check("notimeout_words", cap_q.size(), 2);
    if (cap_q.size() >= 2) check("notimeout_lo", cap_q[1], 32'h9999_AAAA);
    check("notimeout_done", n_done - d0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion before 500000ns");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
